muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide engine, instantiated inside the EXE stage of the multi-cycle CPU.
- Executes MULT/MULTU/DIV/DIVU and owns the architectural HI/LO registers.
- EXE stage raises start when EXE_valid and a mul/div opcode are both present.
- EXE holds EXE_over low until done pulses. MFHI/MFLO read hi/lo combinationally in EXE.
- MTHI/MTLO write through hi_wen/lo_wen.

Parameters:
- WIDTH, 32, operand width. The iteration count equals WIDTH. Only 32 is required to be supported.

Ports:
- clk  input  1  clock
- resetn  input  1  reset, synchronous, active-low
- start  input  1  one-cycle request; op/src1/src2 are sampled on this edge
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- src1  input  WIDTH  rs value (multiplicand / dividend)
- src2  input  WIDTH  rt value (multiplier / divisor)
- hi_wen  input  1  MTHI write enable
- lo_wen  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; HI/LO hold the final result in this cycle
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE; busy=0, done=0, hi=0, lo=0.
  - The iteration counter and internal accumulators are cleared.
  - Reset mid-operation abandons the operation; no partial result reaches hi/lo.
- States:
  - IDLE -> CALC on start.
  - CALC -> FINISH when the counter reaches WIDTH-1.
  - FINISH -> IDLE unconditionally.
- Start edge (IDLE, start=1):
  - Latch op.
  - For signed ops, latch the absolute values of src1/src2 plus sign flags; unsigned ops latch operands unchanged.
  - Counter=0; busy=1 from the next cycle.
- CALC performs one iteration per cycle, WIDTH iterations in total:
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
- FINISH: sign correction, then hi/lo are written on the FINISH edge. busy stays 1 during FINISH.
- Timing:
  - start high in cycle 0 -> done=1 in cycle WIDTH+1 (cycle 33 for WIDTH=32).
  - busy=1 in cycles 1..WIDTH+1 and 0 otherwise.
  - hi/lo change only on the edge that raises done, or on hi_wen/lo_wen.
- Result rules:
  - MULT/MULTU: {hi,lo} = 64-bit product. For MULT, the product is negated when sign1^sign2.
  - DIV/DIVU: lo = quotient, hi = remainder. For DIV, the quotient is negated when sign1^sign2, and the remainder takes the sign of src1.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is the natural wrap; no trap.
  - Divide by zero, any divide op: still WIDTH+1 cycles; lo=0xFFFFFFFF, hi=src1 as latched (original signed value for DIV).
- Handshake and conflicts:
  - start while busy=1 is ignored; the operation in progress continues unchanged.
  - hi_wen/lo_wen in IDLE write wdata on that edge.
  - hi_wen/lo_wen while busy=1 are ignored.
  - start and hi_wen in the same IDLE cycle: HI takes wdata on that edge, then the operation proceeds and overwrites HI at completion.
  - start=1 in the same cycle that done=1 is accepted, because that edge returns to IDLE; the following cycle is the start edge.
- Operand sampling: src1/src2/op may change after the start edge without affecting the result.

Test Plan:
1. MULT src1=0xFFFFFFFD (-3), src2=5 -> done exactly 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for cycles 1..33.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIVU 100/7 -> lo=14, hi=2.
3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU 7/0 -> done at cycle 33; lo=0xFFFFFFFF, hi=7. DIV -5/0 -> hi=0xFFFFFFFB.
5. Start a MULT. Pulse start with a DIV and pulse hi_wen (wdata=0x1234) at cycle 10 -> both are ignored; MULT result appears at cycle 33. MTLO 0xABCD while idle -> lo=0xABCD next cycle.
6. Start DIV, assert resetn=0 at cycle 15 -> next cycle busy=0, done=0, hi=lo=0. A new MULT 6x7 after reset -> lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; result and done arrive WIDTH+1 cycles after start.
// start is ignored while busy; MTHI/MTLO writes only land in IDLE.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             hi_wen,
    input  logic             lo_wen,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t             state;
    logic               is_div;
    logic               sign1;
    logic               sign2;
    logic               div_zero;
    logic [WIDTH-1:0]   opd;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic               is_signed;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;

    always_comb begin
        is_signed = ~op[0];
        abs1      = (is_signed && src1[WIDTH-1]) ? -src1 : src1;
        abs2      = (is_signed && src2[WIDTH-1]) ? -src2 : src2;
    end

    // Multiply keeps the multiplier in acc's low half and shifts the product in from the top;
    // divide keeps the dividend/quotient in acc's low half and the remainder in rem.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc_nx;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_nx;
    logic [WIDTH-1:0]   div_q_nx;
    logic               div_unused;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rmd;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    always_comb begin
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
        mul_acc_nx = {mul_sum, acc[WIDTH-1:1]};

        div_shift  = {rem, acc[WIDTH-1]};
        div_diff   = {1'b0, div_shift} - {2'b00, opd};
        div_ge     = ~div_diff[WIDTH+1];
        div_rem_nx = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_q_nx   = {acc[WIDTH-2:0], div_ge};
        div_unused = div_diff[WIDTH];

        prod = (sign1 ^ sign2) ? -mul_acc_nx : mul_acc_nx;
        quo  = (sign1 ^ sign2) ? -div_q_nx : div_q_nx;
        if (div_zero) begin
            quo = {WIDTH{1'b1}};
        end
        rmd  = sign1 ? -div_rem_nx : div_rem_nx;

        fin_hi = is_div ? rmd : prod[2*WIDTH-1:WIDTH];
        fin_lo = is_div ? quo : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            is_div   <= 1'b0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            div_zero <= 1'b0;
            opd      <= '0;
            rem      <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (hi_wen) hi <= wdata;
                    if (lo_wen) lo <= wdata;
                    if (start) begin
                        is_div   <= op[1];
                        sign1    <= is_signed & src1[WIDTH-1];
                        sign2    <= is_signed & src2[WIDTH-1];
                        div_zero <= op[1] && (src2 == '0);
                        opd      <= op[1] ? abs2 : abs1;
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? abs1 : abs2)};
                        rem      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc <= {acc[2*WIDTH-1:WIDTH], div_q_nx};
                        rem <= div_rem_nx;
                    end else begin
                        acc <= mul_acc_nx;
                    end
                    cnt <= cnt + 1'b1;
                    // Last iteration folds in sign correction so HI/LO are valid with done.
                    if (cnt == CW'(WIDTH - 1)) begin
                        hi    <= fin_hi;
                        lo    <= fin_lo;
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: result values, done latency, busy window and HI/LO conflicts.
module tb_muldiv_unit;
    logic        clk;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        hi_wen;
    logic        lo_wen;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .hi_wen (hi_wen),
        .lo_wen (lo_wen),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Caller is in an IDLE cycle; returns one cycle after done, with the values seen in the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int done_cyc, output bit busy_ok,
                          output logic [31:0] hi_v, output logic [31:0] lo_v);
        op = o; src1 = a; src2 = b; start = 1'b1;
        step();
        start = 1'b0;
        src1 = $urandom; src2 = $urandom; op = 2'($urandom_range(0, 3));
        done_cyc = -1;
        busy_ok  = 1'b1;
        hi_v     = 'x;
        lo_v     = 'x;
        for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                done_cyc = k;
                hi_v = hi;
                lo_v = lo;
            end else begin
                step();
            end
        end
        step();
        if (busy || done) busy_ok = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int          dc;
        bit          bok;
        logic [31:0] hv;
        logic [31:0] lv;
        logic [31:0] hold_hi;

        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
        vecs[6]  = '{2'b11, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
        vecs[7]  = '{2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[10] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};

        resetn = 1'b0; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
        hi_wen = 1'b0; lo_wen = 1'b0; wdata = '0;
        step(); step(); step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        resetn = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, dc, bok, hv, lv);
            chk($sformatf("vec%0d_done_cycle", i), 64'(dc), 64'd33);
            chk($sformatf("vec%0d_busy_window", i), 64'(bok), 64'd1);
            chk($sformatf("vec%0d_hi", i), 64'(hv), 64'(vecs[i].exp_hi));
            chk($sformatf("vec%0d_lo", i), 64'(lv), 64'(vecs[i].exp_lo));
        end

        // start and hi_wen in flight: DIV request and MTHI at cycle 10 are both dropped
        op = 2'b00; src1 = 32'h1000; src2 = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 10; k++) step();
        hold_hi = hi;
        start = 1'b1; op = 2'b10; src1 = 32'd50; src2 = 32'd5; hi_wen = 1'b1; wdata = 32'h1234;
        step();
        start = 1'b0; hi_wen = 1'b0;
        chk("busy_hi_wen_ignored", 64'(hi), 64'(hold_hi));
        chk("busy_mid_op", 64'(busy), 64'd1);
        dc = -1;
        for (int k = 11; k <= 45 && dc < 0; k++) begin
            if (done) dc = k;
            else step();
        end
        chk("busy_start_done_cycle", 64'(dc), 64'd33);
        chk("busy_start_hi", 64'(hi), 64'd0);
        chk("busy_start_lo", 64'(lo), 64'h3000);
        step();
        chk("dropped_start_idle0", 64'(busy), 64'd0);
        step();
        chk("dropped_start_idle1", 64'(busy), 64'd0);

        lo_wen = 1'b1; wdata = 32'hABCD;
        step();
        lo_wen = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'hABCD);
        chk("mtlo_hi_kept", 64'(hi), 64'd0);

        // MTHI in the start cycle lands first, then the result overwrites it
        op = 2'b01; src1 = 32'd9; src2 = 32'd9; start = 1'b1; hi_wen = 1'b1; wdata = 32'h5555;
        step();
        start = 1'b0; hi_wen = 1'b0;
        chk("start_mthi_hi", 64'(hi), 64'h5555);
        dc = -1;
        for (int k = 1; k <= 40 && dc < 0; k++) begin
            if (done) dc = k;
            else step();
        end
        chk("start_mthi_done_cycle", 64'(dc), 64'd33);
        chk("start_mthi_final_hi", 64'(hi), 64'd0);
        chk("start_mthi_final_lo", 64'(lo), 64'd81);
        step();

        // reset in the middle of a divide abandons it
        op = 2'b10; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 15; k++) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_hi", 64'(hi), 64'd0);
        chk("midreset_lo", 64'(lo), 64'd0);
        bok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (done || busy || hi != 0 || lo != 0) bok = 1'b0;
            step();
        end
        chk("midreset_no_result", 64'(bok), 64'd1);

        run_op(2'b00, 32'd6, 32'd7, dc, bok, hv, lv);
        chk("post_reset_done_cycle", 64'(dc), 64'd33);
        chk("post_reset_hi", 64'(hv), 64'd0);
        chk("post_reset_lo", 64'(lv), 64'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
